// File: rtl/cache_pkg.sv
// Shared types, funct3 codes and address-field width helpers for the data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } cache_state_t;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic int word_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_width, input int sets, input int words_per_line);
        return addr_width - $clog2(sets) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and backing-memory-side signals of the data cache.
// slave is the cache's view, master is the view of whoever drives the cache.
interface data_cache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [2:0]            cpu_ctrl_i;
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic [31:0]           cpu_wdata_i;
    logic [31:0]           cpu_rdata_o;
    logic                  cpu_stall_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o;
    logic [3:0]            mem_wstrb_o;
    logic                  mem_ack_i;
    logic [31:0]           mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_ctrl_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_ctrl_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/data_cache_store.sv
// Tag/valid/data storage for the direct-mapped cache. Reads are combinational;
// data is held as four byte-lane arrays so a strobed write touches only its lanes.
module cache_store #(
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24,
    localparam int IDX_W         = $clog2(SETS),
    localparam int WORD_W        = $clog2(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    input  logic              set_en,
    input  logic [IDX_W-1:0]  set_index,
    input  logic [TAG_W-1:0]  set_tag
);
    localparam int DEPTH = SETS * WORDS_PER_LINE;

    logic [SETS-1:0]         valid_reg;
    logic [TAG_W-1:0]        tag_mem [SETS];
    logic [IDX_W+WORD_W-1:0] rd_addr;
    logic [IDX_W+WORD_W-1:0] wr_addr;

    assign rd_addr  = {rd_index, rd_word};
    assign wr_addr  = {wr_index, wr_word};
    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            // Byte lane gi is written only when its strobe is set
            always_ff @(posedge clk) begin
                if (wr_en && wr_strb[gi]) begin
                    lane_mem[wr_addr] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_data[8*gi +: 8] = lane_mem[rd_addr];
        end
    endgenerate

    // Tag is captured together with the valid bit at the end of a refill
    always_ff @(posedge clk) begin
        if (set_en) begin
            tag_mem[set_index] <= set_tag;
        end
    end

    // Valid bits are the only storage cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (set_en) begin
            valid_reg[set_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Loads that miss refill a whole line word by word; every store goes to memory.
module data_cache import cache_pkg::*; #(
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic         clk,
    input  logic         rst,
    data_cache_if.slave  bus
);
    localparam int WORD_W = word_bits(WORDS_PER_LINE);
    localparam int IDX_W  = index_bits(SETS);
    localparam int TAG_W  = tag_bits(ADDR_WIDTH, SETS, WORDS_PER_LINE);

    cache_state_t            state_reg, state_next;
    logic [WORD_W-1:0]       count_reg, count_next;

    logic [WORD_W-1:0]       addr_word;
    logic [IDX_W-1:0]        addr_index;
    logic [TAG_W-1:0]        addr_tag;
    logic                    rd_valid;
    logic [TAG_W-1:0]        rd_tag;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    hit;

    logic                    wr_en;
    logic [WORD_W-1:0]       wr_word;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [3:0]              wr_strb;
    logic                    set_en;

    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [DATA_WIDTH-1:0]   store_data;
    logic [3:0]              store_strb;

    logic                    stall;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [3:0]              mem_wstrb;

    assign addr_word  = bus.cpu_addr_i[WORD_W+1:2];
    assign addr_index = bus.cpu_addr_i[WORD_W+2 +: IDX_W];
    assign addr_tag   = bus.cpu_addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign hit        = rd_valid && (rd_tag == addr_tag);

    cache_store #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (addr_index),
        .rd_word   (addr_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_index  (addr_index),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .set_en    (set_en),
        .set_index (addr_index),
        .set_tag   (addr_tag)
    );

    // Pick the addressed lane and sign/zero-extend it for writeback
    always_comb begin
        lane_byte = rd_data[{bus.cpu_addr_i[1:0], 3'b000} +: 8];
        lane_half = bus.cpu_addr_i[1] ? rd_data[31:16] : rd_data[15:0];
        case (bus.cpu_ctrl_i)
            LB:      load_data = {{24{lane_byte[7]}}, lane_byte};
            LH:      load_data = {{16{lane_half[15]}}, lane_half};
            LBU:     load_data = {24'd0, lane_byte};
            LHU:     load_data = {16'd0, lane_half};
            default: load_data = rd_data;
        endcase
    end

    // Replicate narrow store data across all lanes and build the byte strobes
    always_comb begin
        case (bus.cpu_ctrl_i)
            SB: begin
                store_data = {4{bus.cpu_wdata_i[7:0]}};
                store_strb = 4'b0001 << bus.cpu_addr_i[1:0];
            end
            SH: begin
                store_data = {2{bus.cpu_wdata_i[15:0]}};
                store_strb = 4'b0011 << {bus.cpu_addr_i[1], 1'b0};
            end
            default: begin
                store_data = bus.cpu_wdata_i;
                store_strb = 4'hF;
            end
        endcase
    end

    // FSM next state, stall, memory request and array write control
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = 4'h0;
        wr_en      = 1'b0;
        wr_word    = addr_word;
        wr_data    = store_data;
        wr_strb    = store_strb;
        set_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.cpu_req_i) begin
                    if (bus.cpu_we_i) begin
                        stall      = 1'b1;
                        state_next = WRITE;
                    end else if (!hit) begin
                        stall      = 1'b1;
                        count_next = '0;
                        state_next = REFILL;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {bus.cpu_addr_i[ADDR_WIDTH-1:WORD_W+2], count_reg, 2'b00};
                if (bus.mem_ack_i) begin
                    wr_en      = 1'b1;
                    wr_word    = count_reg;
                    wr_data    = bus.mem_rdata_i;
                    wr_strb    = 4'hF;
                    count_next = count_reg + 1'b1;
                    if (&count_reg) begin
                        set_en     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                stall     = !bus.mem_ack_i;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {bus.cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata = store_data;
                mem_wstrb = store_strb;
                if (bus.mem_ack_i) begin
                    // Write-through: only an already-present line is updated
                    wr_en      = hit;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and refill word counter; reset aborts any memory transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    assign bus.cpu_stall_o = stall;
    assign bus.cpu_rdata_o = (state_reg == IDLE && bus.cpu_req_i && !bus.cpu_we_i && hit)
                             ? load_data : '0;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.mem_wstrb_o = mem_wstrb;

endmodule

// File: tb/tb_data_cache.sv
// Randomized scoreboard bench for data_cache: a line-level cache/memory model
// predicts load results, stall lengths and the exact memory transactions.
module tb_data_cache;
    import cache_pkg::*;

    localparam int SETS = 16;
    localparam int WPL  = 4;
    localparam int AW   = 32;
    localparam int WB   = $clog2(WPL);
    localparam int IB   = $clog2(SETS);

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        int          stalls;
        logic [31:0] addr;
    } cpu_exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_cache_if #(.ADDR_WIDTH(AW)) bus ();

    data_cache #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WPL),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cpu_exp_t    cpu_q[$];
    mem_exp_t    mem_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          lat = 1;
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] bus_mem [int unsigned];
    bit          mvalid [SETS];
    logic [31:0] mtag [SETS];
    logic [2:0]  ld_ops [5] = '{LB, LH, LW, LBU, LHU};
    logic [2:0]  st_ops [3] = '{SB, SH, SW};

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] bus_get(input logic [31:0] wa);
        if (bus_mem.exists(wa)) return bus_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] c, input int off);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (c)
            3'b000:  return (b >= 128) ? b - 32'd256 : b;
            3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [31:0] wa, input logic [31:0] val);
        ref_mem[wa] = val;
        bus_mem[wa] = val;
    endtask

    // Predict the outcome, queue expectations, then drive one access to completion
    task automatic access(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata);
        cpu_exp_t    e;
        mem_exp_t    m;
        logic [31:0] wa;
        logic [31:0] tag;
        logic [31:0] old;
        logic [31:0] nw;
        logic [31:0] wd;
        logic [3:0]  st;
        int unsigned idx;
        int          off;
        int          n;
        bit          hit;
        wa  = {addr[31:2], 2'b00};
        idx = (addr >> (2 + WB)) % SETS;
        tag = addr >> (2 + WB + IB);
        off = int'(addr[1:0]);
        e.addr = addr;
        if (!we) begin
            hit = mvalid[idx] && (mtag[idx] == tag);
            if (!hit) begin
                for (int k = 0; k < WPL; k++) begin
                    m.we    = 1'b0;
                    m.addr  = (addr & ~(WPL * 4 - 1)) + 4 * k;
                    m.strb  = 4'h0;
                    m.wdata = 32'h0;
                    mem_q.push_back(m);
                end
                mvalid[idx] = 1'b1;
                mtag[idx]   = tag;
            end
            e.is_load = 1'b1;
            e.rdata   = ref_load(ref_get(wa), ctrl, off);
            e.stalls  = hit ? 0 : WPL * lat + 1;
        end else begin
            old = ref_get(wa);
            case (ctrl)
                3'b000: begin
                    st = 4'(32'd1 << off);
                    wd = (wdata & 32'hFF) * 32'h0101_0101;
                end
                3'b001: begin
                    st = 4'(32'd3 << (off & 2));
                    wd = (wdata & 32'hFFFF) * 32'h0001_0001;
                end
                default: begin
                    st = 4'hF;
                    wd = wdata;
                end
            endcase
            nw = old;
            for (int i = 0; i < 4; i++) begin
                if (st[i]) nw[8*i +: 8] = wd[8*i +: 8];
            end
            ref_mem[wa] = nw;
            m.we    = 1'b1;
            m.addr  = wa;
            m.strb  = st;
            m.wdata = wd;
            mem_q.push_back(m);
            e.is_load = 1'b0;
            e.rdata   = 32'h0;
            e.stalls  = lat;
        end
        cpu_q.push_back(e);

        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_ctrl_i  = ctrl;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.cpu_stall_o && n < 400);
        if (bus.cpu_stall_o) begin
            n_errors++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, n);
            $fatal(1, "access timeout");
        end
        @(posedge clk);
        #2;
        bus.cpu_req_i = 1'b0;
    endtask

    // Abort a refill with reset while the second word is being requested
    task automatic reset_mid_refill(input logic [31:0] addr);
        mem_exp_t m;
        int       n;
        lat = 2;
        for (int k = 0; k < 2; k++) begin
            m.we    = 1'b0;
            m.addr  = addr + 4 * k;
            m.strb  = 4'h0;
            m.wdata = 32'h0;
            mem_q.push_back(m);
        end
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_ctrl_i = LW;
        bus.cpu_addr_i = addr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.mem_req_o && bus.mem_addr_o == addr + 32'd4) && n < 50);
        if (n >= 50) begin
            n_errors++;
            $display("FAIL abort_wait: second refill word never requested, got addr %h", bus.mem_addr_o);
            $fatal(1, "abort wait timeout");
        end
        #1 rst = 1'b1;
        #1 chk("rst_drops_mem_req", 32'(bus.mem_req_o), 32'h0);
        bus.cpu_req_i = 1'b0;
        for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
    endtask

    // Backing memory: ack after lat cycles, check each request and its stability
    initial begin
        int          cnt;
        mem_exp_t    m;
        logic [68:0] cap;
        logic [68:0] cur;
        logic [31:0] w;
        cnt = 0;
        cap = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack_i = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (bus.mem_req_o) begin
                cur = {bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o};
                if (cnt == 0) begin
                    cap = cur;
                    if (mem_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL mem_unexpected: got we=%0b addr %h, required no request",
                                 bus.mem_we_o, bus.mem_addr_o);
                    end else begin
                        m = mem_q.pop_front();
                        chk("mem_we", 32'(bus.mem_we_o), 32'(m.we));
                        chk("mem_addr", bus.mem_addr_o, m.addr);
                        if (m.we) begin
                            chk("mem_wstrb", 32'(bus.mem_wstrb_o), 32'(m.strb));
                            chk("mem_wdata", bus.mem_wdata_o, m.wdata);
                        end
                    end
                end else begin
                    n_checks++;
                    if (cur !== cap) begin
                        n_errors++;
                        $display("FAIL mem_hold: got %h required %h", cur, cap);
                    end
                end
                cnt++;
                if (cnt >= lat) begin
                    bus.mem_ack_i = 1'b1;
                    if (!bus.mem_we_o) begin
                        bus.mem_rdata_i = bus_get(bus.mem_addr_o);
                    end else begin
                        w = bus_get(bus.mem_addr_o);
                        for (int i = 0; i < 4; i++) begin
                            if (bus.mem_wstrb_o[i]) w[8*i +: 8] = bus.mem_wdata_o[8*i +: 8];
                        end
                        bus_mem[bus.mem_addr_o] = w;
                    end
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // CPU-side monitor: count stall cycles and check each completed access
    initial begin
        int       sc;
        cpu_exp_t e;
        sc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sc = 0;
            end else if (bus.cpu_req_i) begin
                if (bus.cpu_stall_o) begin
                    sc++;
                end else if (cpu_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL cpu_unexpected: access at %h completed with none pending", bus.cpu_addr_i);
                    sc = 0;
                end else begin
                    e = cpu_q.pop_front();
                    chk("stall_cycles", 32'(sc), 32'(e.stalls));
                    if (e.is_load) chk("load_data", bus.cpu_rdata_o, e.rdata);
                    $display("txn %s addr=%h rdata=%h stalls=%0d", e.is_load ? "LD" : "ST",
                             e.addr, bus.cpu_rdata_o, sc);
                    sc = 0;
                end
            end else begin
                chk("idle_no_stall", 32'(bus.cpu_stall_o), 32'h0);
            end
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        int          op;
        logic [31:0] a;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_ctrl_i  = 3'b000;
        bus.cpu_addr_i  = '0;
        bus.cpu_wdata_i = '0;
        for (int i = 0; i < SETS; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end

        #1 rst = 1'b1;
        #2;
        chk("rst_mem_req",   32'(bus.mem_req_o),   32'h0);
        chk("rst_mem_we",    32'(bus.mem_we_o),    32'h0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb_o), 32'h0);
        chk("rst_mem_addr",  bus.mem_addr_o,       32'h0);
        chk("rst_mem_wdata", bus.mem_wdata_o,      32'h0);
        chk("rst_stall",     32'(bus.cpu_stall_o), 32'h0);
        chk("rst_rdata",     bus.cpu_rdata_o,      32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;

        lat = 1;
        access(1'b0, LW, 32'h100, 32'h0);
        access(1'b0, LW, 32'h108, 32'h0);

        preset(32'h200, 32'h8081_82F0);
        access(1'b0, LW,  32'h200, 32'h0);
        access(1'b0, LB,  32'h200, 32'h0);
        access(1'b0, LBU, 32'h200, 32'h0);
        access(1'b0, LH,  32'h202, 32'h0);
        access(1'b0, LHU, 32'h202, 32'h0);

        lat = 2;
        access(1'b1, SB, 32'h203, 32'h0000_00AA);
        access(1'b0, LW, 32'h200, 32'h0);

        lat = 1;
        access(1'b1, SW, 32'h400, 32'h1234_5678);
        access(1'b0, LW, 32'h400, 32'h0);

        access(1'b0, LW, 32'h100, 32'h0);
        access(1'b0, LW, 32'h500, 32'h0);
        access(1'b0, LW, 32'h100, 32'h0);

        reset_mid_refill(32'h600);
        lat = 1;
        access(1'b0, LW, 32'h600, 32'h0);

        for (int t = 0; t < 400; t++) begin
            lat = int'($urandom_range(1, 3));
            op  = int'($urandom_range(0, 7));
            a   = $urandom_range(0, 32'h7FF);
            if (op < 5) access(1'b0, ld_ops[op], a, 32'h0);
            else        access(1'b1, st_ops[op-5], a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
            end
        end

        repeat (4) @(posedge clk);
        chk("cpu_queue_drained", 32'(cpu_q.size()), 32'h0);
        chk("mem_queue_drained", 32'(mem_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
